mac_tx_ctrl: RTL and testbench

//  Transmit-side frame sequencer feeding the PCS encoder; mirror image of the mac_rx ingress interface.

---
 rtl/mac_tx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mac_tx_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_ctrl.sv
// Transmit frame sequencer: preamble/SFD, payload, terminate and inter-frame gap towards the PCS encoder.
// Define MAC_TX_STATS_EN to add saturating frame/abort counters (frame_cnt_o, abort_cnt_o).
module mac_tx_ctrl #(
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int IFG_BYTES = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic [KEEP_W-1:0] s_keep_i,
    input  logic              s_last_i,
    input  logic              pcs_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ctrl_v_o,
    output logic              idle_o,
    output logic              start_o,
    output logic              term_o,
    output logic [KEEP_W-1:0] term_keep_o,
    output logic              cancel_o
`ifdef MAC_TX_STATS_EN
    ,
    output logic [31:0]       frame_cnt_o,
    output logic [15:0]       abort_cnt_o
`endif
);

    localparam int PRE_CYC = 8 / KEEP_W;
    localparam int IFG_CYC = IFG_BYTES / KEEP_W;
    localparam int CNT_W   = 16;
    localparam logic [63:0] PRE_WORD = 64'hAAAAAAAAAAAAAAAB;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_TERM  = 3'd3;
    localparam logic [2:0] ST_IFG   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] data_n;
    logic [KEEP_W-1:0] tkeep_n;
    logic              ctrl_n, idle_n, start_n, term_n, cancel_n;

    // Upstream only moves in the payload and drain phases, and only when the PCS takes a symbol.
    assign s_ready_o = pcs_ready_i && (state == ST_DATA || state == ST_DRAIN);

    // Next symbol and state; only applied on cycles where pcs_ready_i is high.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        data_n   = '0;
        tkeep_n  = '0;
        ctrl_n   = 1'b1;
        idle_n   = 1'b1;
        start_n  = 1'b0;
        term_n   = 1'b0;
        cancel_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid_i) begin
                    state_n = ST_PRE;
                    cnt_n   = '0;
                end
            end
            ST_PRE: begin
                data_n  = DATA_W'(PRE_WORD >> (DATA_W * int'(cnt)));
                idle_n  = 1'b0;
                start_n = (cnt == '0);
                ctrl_n  = (cnt == '0);
                if (cnt == CNT_W'(PRE_CYC - 1)) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (s_valid_i) begin
                    data_n = s_data_i;
                    idle_n = 1'b0;
                    ctrl_n = 1'b0;
                    if (s_last_i) begin
                        if (&s_keep_i) begin
                            state_n = ST_TERM;
                        end else begin
                            // A partial tail rides inside the terminate symbol itself.
                            ctrl_n  = 1'b1;
                            term_n  = 1'b1;
                            tkeep_n = s_keep_i;
                            state_n = ST_IFG;
                            cnt_n   = CNT_W'(IFG_CYC - 1);
                        end
                    end
                end else begin
                    cancel_n = 1'b1;
                    state_n  = ST_DRAIN;
                end
            end
            ST_TERM: begin
                idle_n  = 1'b0;
                term_n  = 1'b1;
                state_n = ST_IFG;
                cnt_n   = CNT_W'(IFG_CYC - 1);
            end
            ST_IFG: begin
                if (cnt == '0) begin
                    state_n = s_valid_i ? ST_PRE : ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (s_valid_i && s_last_i) begin
                    state_n = ST_IFG;
                    cnt_n   = CNT_W'(IFG_CYC - 1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // A PCS slip freezes everything; cancel is dropped so it stays a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            ctrl_v_o    <= 1'b0;
            idle_o      <= 1'b0;
            start_o     <= 1'b0;
            term_o      <= 1'b0;
            term_keep_o <= '0;
            cancel_o    <= 1'b0;
        end else if (pcs_ready_i) begin
            state       <= state_n;
            cnt         <= cnt_n;
            valid_o     <= 1'b1;
            data_o      <= data_n;
            ctrl_v_o    <= ctrl_n;
            idle_o      <= idle_n;
            start_o     <= start_n;
            term_o      <= term_n;
            term_keep_o <= tkeep_n;
            cancel_o    <= cancel_n;
        end else begin
            valid_o  <= 1'b0;
            cancel_o <= 1'b0;
        end
    end

`ifdef MAC_TX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_o <= '0;
            abort_cnt_o <= '0;
        end else if (pcs_ready_i) begin
            if (term_n && frame_cnt_o != '1) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end
            if (cancel_n && abort_cnt_o != '1) begin
                abort_cnt_o <= abort_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Directed bench for mac_tx_ctrl at DATA_W=16: frame framing, partial tail, back-to-back IFG,
// underrun/drain, PCS slip and asynchronous reset.
module tb_mac_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] s_data_i;
    logic [1:0]  s_keep_i;
    logic        s_last_i;
    logic        pcs_ready_i;
    logic        valid_o;
    logic [15:0] data_o;
    logic        ctrl_v_o;
    logic        idle_o;
    logic        start_o;
    logic        term_o;
    logic [1:0]  term_keep_o;
    logic        cancel_o;
`ifdef MAC_TX_STATS_EN
    logic [31:0] frame_cnt_o;
    logic [15:0] abort_cnt_o;
`endif

    mac_tx_ctrl #(.DATA_W(16), .KEEP_W(2), .IFG_BYTES(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_keep_i    (s_keep_i),
        .s_last_i    (s_last_i),
        .pcs_ready_i (pcs_ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ctrl_v_o    (ctrl_v_o),
        .idle_o      (idle_o),
        .start_o     (start_o),
        .term_o      (term_o),
        .term_keep_o (term_keep_o),
        .cancel_o    (cancel_o)
`ifdef MAC_TX_STATS_EN
        ,
        .frame_cnt_o (frame_cnt_o),
        .abort_cnt_o (abort_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gap;
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        ctrl;
        logic        idle;
        logic        start;
        logic        term;
        logic        cancel;
        logic [1:0]  tkeep;
    } sym_t;

    beat_t src_q[$];
    sym_t  log_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int low_cnt = 0;
    int hold_err = 0;
    int excl_err = 0;
    int beats_acc = 0;
    int stall_at = 0;
    int stall_left = 0;
    bit stall_arm = 0;
    logic [15:0] prev_data = '0;

    task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sym_t at(int idx);
        sym_t z;
        z = '{default: '0};
        if (idx >= 0 && idx < log_q.size()) z = log_q[idx];
        return z;
    endfunction

    function automatic int findStart(int from);
        for (int i = from; i < log_q.size(); i++) if (log_q[i].start) return i;
        return -1;
    endfunction

    function automatic int findTerm(int from);
        for (int i = from; i < log_q.size(); i++) if (log_q[i].term) return i;
        return -1;
    endfunction

    function automatic int findCancel(int from);
        for (int i = from; i < log_q.size(); i++) if (log_q[i].cancel) return i;
        return -1;
    endfunction

    function automatic int countIdle(int from, int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (at(i).idle && at(i).ctrl) n++;
        return n;
    endfunction

    function automatic int countCancel();
        int n = 0;
        for (int i = 0; i < log_q.size(); i++) if (log_q[i].cancel) n++;
        return n;
    endfunction

    task automatic pushFrame(int n, logic [15:0] base, logic [1:0] last_keep, int gap_after);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            if (i == gap_after) begin
                b = '{gap: 1'b1, data: '0, keep: '0, last: 1'b0};
                src_q.push_back(b);
            end
            b.gap  = 1'b0;
            b.data = base + 16'(i);
            b.keep = (i == n - 1) ? last_keep : 2'b11;
            b.last = (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    // Upstream source and PCS model, one cycle per iteration, driven at the falling edge.
    task automatic applyStimulus(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall_arm && beats_acc == stall_at) begin
                stall_left = 3;
                stall_arm  = 0;
            end
            pcs_ready_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (src_q.size() > 0 && src_q[0].gap) begin
                s_valid_i = 1'b0;
                void'(src_q.pop_front());
            end else if (src_q.size() > 0) begin
                s_valid_i = 1'b1;
                s_data_i  = src_q[0].data;
                s_keep_i  = src_q[0].keep;
                s_last_i  = src_q[0].last;
            end else begin
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
            end
            #1;
            if (s_valid_i && s_ready_o) begin
                void'(src_q.pop_front());
                beats_acc++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!reset) begin
                if (valid_o) begin
                    log_q.push_back('{cyc: cyc, data: data_o, ctrl: ctrl_v_o, idle: idle_o,
                                      start: start_o, term: term_o, cancel: cancel_o, tkeep: term_keep_o});
                    if (int'(start_o) + int'(term_o) + int'(idle_o) > 1 || (cancel_o && (start_o || term_o)))
                        excl_err++;
                end else begin
                    low_cnt++;
                    if (data_o !== prev_data) hold_err++;
                end
                prev_data = data_o;
            end
        end
    end

    initial begin
        int s, t, s2, c, errs;

        reset = 1'b1;
        s_valid_i = 1'b0;
        s_data_i = '0;
        s_keep_i = '0;
        s_last_i = 1'b0;
        pcs_ready_i = 1'b0;
        #3;
        checkOutput("rst_ctrl", {valid_o, ctrl_v_o, idle_o, start_o, term_o, cancel_o, s_ready_o}, '0);
        checkOutput("rst_data", {data_o, term_keep_o}, '0);
        @(negedge clk);
        reset = 1'b0;
        pcs_ready_i = 1'b1;
        applyStimulus(3);
        checkOutput("idle_after_reset", {at(0).idle, at(0).ctrl, at(0).start}, 3'b110);

        // Full-keep tail: 4 preamble lanes, 10 data beats, empty term, 6 idles.
        log_q.delete();
        pushFrame(10, 16'h1000, 2'b11, -1);
        applyStimulus(30);
        s = findStart(0);
        checkOutput("f1_start", {at(s).start, at(s).ctrl, at(s).idle}, 3'b110);
        checkOutput("f1_sfd_lane", at(s).data, 16'hAAAB);
        errs = 0;
        for (int i = 1; i < 4; i++) if (at(s + i).data !== 16'hAAAA || at(s + i).ctrl !== 1'b0) errs++;
        checkOutput("f1_preamble", errs, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("f1_beat%0d", i), {at(s + 4 + i).ctrl, at(s + 4 + i).data}, {1'b0, 16'h1000 + 16'(i)});
        end
        checkOutput("f1_term", {at(s + 14).term, at(s + 14).ctrl, at(s + 14).tkeep, at(s + 14).data}, {2'b11, 2'b00, 16'h0000});
        checkOutput("f1_ifg_idles", countIdle(s + 15, s + 20), 6);

        // Partial tail: 9 data beats, the 10th byte carried in the term symbol.
        log_q.delete();
        pushFrame(10, 16'h2A50, 2'b01, -1);
        applyStimulus(30);
        s = findStart(0);
        errs = 0;
        for (int i = 0; i < 9; i++) if (at(s + 4 + i).data !== 16'h2A50 + 16'(i) || at(s + 4 + i).ctrl) errs++;
        checkOutput("f2_payload", errs, 0);
        checkOutput("f2_term_pos", findTerm(s), s + 13);
        checkOutput("f2_term_keep", at(s + 13).tkeep, 2'b01);
        checkOutput("f2_term_byte", at(s + 13).data[7:0], 8'h59);
        checkOutput("f2_ifg_idles", countIdle(s + 14, s + 19), 6);

        // Back-to-back: next start exactly 7 symbols after term, 6 idles between.
        log_q.delete();
        pushFrame(4, 16'h3000, 2'b11, -1);
        pushFrame(3, 16'h4000, 2'b11, -1);
        applyStimulus(40);
        s = findStart(0);
        t = findTerm(s);
        s2 = findStart(t);
        checkOutput("b2b_term_pos", t, s + 8);
        checkOutput("b2b_gap_cycles", at(s2).cyc - at(t).cyc, 7);
        checkOutput("b2b_gap_idles", countIdle(t + 1, s2 - 1), 6);
        checkOutput("b2b_second_beat0", at(s2 + 4).data, 16'h4000);

        // Underrun after 5 beats: cancel, drain 5 beats as idles, 6 IFG idles, then next frame.
        log_q.delete();
        pushFrame(10, 16'h5000, 2'b11, 5);
        pushFrame(2, 16'h6000, 2'b11, -1);
        applyStimulus(50);
        s = findStart(0);
        c = findCancel(s);
        errs = 0;
        for (int i = 0; i < 5; i++) if (at(s + 4 + i).data !== 16'h5000 + 16'(i)) errs++;
        checkOutput("ur_payload", errs, 0);
        checkOutput("ur_cancel_pos", c, s + 9);
        checkOutput("ur_cancel_idle", {at(c).idle, at(c).ctrl, at(c).term}, 3'b110);
        checkOutput("ur_cancel_once", countCancel(), 1);
        s2 = findStart(c);
        checkOutput("ur_next_start", s2 - c, 12);
        checkOutput("ur_drain_idles", countIdle(c + 1, s2 - 1), 11);
        checkOutput("ur_next_beat0", at(s2 + 4).data, 16'h6000);

        // PCS slip of 3 cycles after the 4th beat: stream intact, data held.
        log_q.delete();
        low_cnt = 0;
        hold_err = 0;
        beats_acc = 0;
        stall_at = 4;
        stall_arm = 1;
        pushFrame(10, 16'h7000, 2'b11, -1);
        applyStimulus(35);
        s = findStart(0);
        checkOutput("slip_low_cycles", low_cnt, 3);
        checkOutput("slip_hold", hold_err, 0);
        errs = 0;
        for (int i = 0; i < 10; i++) if (at(s + 4 + i).data !== 16'h7000 + 16'(i) || at(s + 4 + i).ctrl) errs++;
        checkOutput("slip_payload", errs, 0);
        checkOutput("slip_term_pos", findTerm(s), s + 14);
        checkOutput("slip_no_cancel", countCancel(), 0);
        checkOutput("exclusive_flags", excl_err, 0);

`ifdef MAC_TX_STATS_EN
        checkOutput("stats_frames", frame_cnt_o, 6);
        checkOutput("stats_aborts", abort_cnt_o, 1);
`endif

        // Asynchronous reset mid-frame.
        pushFrame(10, 16'h8000, 2'b11, -1);
        applyStimulus(8);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_ctrl", {valid_o, ctrl_v_o, idle_o, start_o, term_o, cancel_o, s_ready_o}, '0);
        checkOutput("midrst_data", {data_o, term_keep_o}, '0);
`ifdef MAC_TX_STATS_EN
        checkOutput("midrst_stats", {frame_cnt_o, abort_cnt_o}, '0);
`endif
        src_q.delete();
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        log_q.delete();
        pushFrame(2, 16'h9000, 2'b01, -1);
        applyStimulus(20);
        s = findStart(0);
        checkOutput("post_rst_beat0", at(s + 4).data, 16'h9000);
        checkOutput("post_rst_term", {at(s + 5).term, at(s + 5).tkeep, at(s + 5).data[7:0]}, {1'b1, 2'b01, 8'h01});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
